// File: rtl/ntt_pkg.sv
// ntt_pkg: shared definitions for the iterative negacyclic NTT core.
//   - default transform parameters (N, D, Q, PSI)
//   - default twiddle table tw[k] = PSI^bitrev(k) mod Q for the default D
//   - bitrev / twiddle helper functions (usable in constant context)
//   - FSM state encoding for ntt_iter
package ntt_pkg;

  localparam int unsigned NTT_N   = 17;
  localparam int unsigned NTT_D   = 8;
  localparam int unsigned NTT_Q   = 65537;
  localparam int unsigned NTT_PSI = 4;

  // tw[k] = PSI^bitrev3(k) mod Q for the default parameter set
  localparam logic [16:0] NTT_TW_DEFAULT [8] = '{
    17'd1, 17'd256, 17'd16, 17'd4096, 17'd4, 17'd1024, 17'd64, 17'd16384
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } ntt_state_e;

  // Reverse the low 'bits' bits of v.
  function automatic int unsigned bitrev(input int unsigned v, input int unsigned bits);
    int unsigned r;
    r = 32'd0;
    for (int unsigned m = 0; m < bits; m++) begin
      r = (r << 1) | ((v >> m) & 32'd1);
    end
    return r;
  endfunction

  // Twiddle for table slot k: PSI raised to bitrev(k), reduced mod q.
  function automatic longint unsigned twiddle(input int unsigned k, input int unsigned logd,
                                              input longint unsigned q, input longint unsigned psi);
    longint unsigned r;
    int unsigned     e;
    r = 64'd1;
    e = bitrev(k, logd);
    for (int unsigned m = 0; m < e; m++) begin
      r = (r * psi) % q;
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_ct_pe.sv
// ntt_ct_pe: combinational Cooley-Tukey butterfly over Z_Q.
//   u, v, s : operands, each < Q
//   sum     : (u + v*s) mod Q
//   diff    : (u - v*s) mod Q
// The product is kept at full 2N width before reduction so no bits are lost.
module ntt_ct_pe #(
  parameter int unsigned N = 17,
  parameter int unsigned Q = 65537
) (
  input  logic [N-1:0] u,
  input  logic [N-1:0] v,
  input  logic [N-1:0] s,
  output logic [N-1:0] sum,
  output logic [N-1:0] diff
);

  localparam logic [2*N-1:0] Q_W  = (2*N)'(Q);
  localparam logic [N:0]     Q_N1 = (N+1)'(Q);

  logic [2*N-1:0] prod_s;
  logic [N-1:0]   vr_s;
  logic [N:0]     add_s;

  // Modular multiply, then conditional-correction add and subtract.
  always_comb begin
    prod_s = {{N{1'b0}}, v} * {{N{1'b0}}, s};
    vr_s   = N'(prod_s % Q_W);
    add_s  = {1'b0, u} + {1'b0, vr_s};
    if (add_s >= Q_N1) begin
      sum = N'(add_s - Q_N1);
    end else begin
      sum = N'(add_s);
    end
    if (u >= vr_s) begin
      diff = u - vr_s;
    end else begin
      diff = N'({1'b0, u} + Q_N1 - {1'b0, vr_s});
    end
  end

endmodule

// File: rtl/ntt_iter.sv
// ntt_iter: iterative forward negacyclic NTT, one CT butterfly per cycle.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : input block handshake, a = D packed N-bit coefficients
//   out_valid/out_ready : result handshake, an = D packed N-bit coefficients
//   busy                : high while butterflies are running
// Output order is bit-reversed (the order the INTT consumes). Defining
// NTT_NATURAL_ORDER_EN permutes 'an' combinationally into natural order.
module ntt_iter
  import ntt_pkg::*;
#(
  parameter int unsigned N   = NTT_N,
  parameter int unsigned D   = NTT_D,
  parameter int unsigned Q   = NTT_Q,
  parameter int unsigned PSI = NTT_PSI
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*D-1:0] a,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*D-1:0] an,
  output logic           busy
);

  localparam int unsigned LOGD = $clog2(D);
  localparam int unsigned HALF = D / 2;
  localparam int unsigned IW   = LOGD;
  localparam int unsigned SW   = (LOGD > 1) ? $clog2(LOGD) : 1;
  localparam int unsigned BW   = (LOGD > 1) ? LOGD - 1 : 1;

  ntt_state_e    state_r;
  logic [N-1:0]  buf_r [D];
  logic [SW-1:0] stage_r;
  logic [BW-1:0] bfly_r;
  logic          in_ready_r;
  logic          out_valid_r;
  logic          busy_r;

  logic [N-1:0]  tw_s [D];
  logic [IW-1:0] t_s;
  logic [SW-1:0] sh_s;
  logic [IW-1:0] grp_s;
  logic [IW-1:0] off_s;
  logic [IW-1:0] j_s;
  logic [IW-1:0] jt_s;
  logic [IW-1:0] tw_idx_s;
  logic          last_s;
  logic [N-1:0]  sum_s;
  logic [N-1:0]  diff_s;

  // Twiddle ROM: the default set comes from the package, others are folded at elaboration.
  for (genvar k = 0; k < D; k++) begin : g_tw
    if (D == NTT_D && Q == NTT_Q && PSI == NTT_PSI) begin : g_dflt
      assign tw_s[k] = N'(NTT_TW_DEFAULT[k]);
    end else begin : g_calc
      assign tw_s[k] = N'(twiddle(k, LOGD, Q, PSI));
    end
  end

  // Butterfly addressing: t = D>>(s+1) = 2^sh, group i = b>>sh, j = 2*i*t + (b mod t).
  always_comb begin
    t_s      = IW'(HALF) >> stage_r;
    sh_s     = SW'(LOGD - 1) - stage_r;
    grp_s    = IW'(bfly_r) >> sh_s;
    off_s    = IW'(bfly_r) & (t_s - IW'(1'b1));
    j_s      = ((grp_s << 1) << sh_s) | off_s;
    jt_s     = j_s + t_s;
    tw_idx_s = (IW'(1'b1) << stage_r) + grp_s;
    last_s   = (stage_r == SW'(LOGD - 1)) && (bfly_r == BW'(HALF - 1));
  end

  ntt_ct_pe #(
    .N (N),
    .Q (Q)
  ) u_pe (
    .u    (buf_r[j_s]),
    .v    (buf_r[jt_s]),
    .s    (tw_idx_s == IW'(1'b0) ? tw_s[0] : tw_s[tw_idx_s]),
    .sum  (sum_s),
    .diff (diff_s)
  );

  // Control FSM, coefficient buffer and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      stage_r     <= '0;
      bfly_r      <= '0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      for (int k = 0; k < D; k++) begin
        buf_r[k] <= '0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            for (int k = 0; k < D; k++) begin
              buf_r[k] <= a[k*N +: N];
            end
            stage_r    <= '0;
            bfly_r     <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
            state_r    <= RUN;
          end
        end
        RUN: begin
          buf_r[j_s]  <= sum_s;
          buf_r[jt_s] <= diff_s;
          if (last_s) begin
            stage_r     <= '0;
            bfly_r      <= '0;
            busy_r      <= 1'b0;
            out_valid_r <= 1'b1;
            state_r     <= DONE;
          end else if (bfly_r == BW'(HALF - 1)) begin
            bfly_r  <= '0;
            stage_r <= stage_r + SW'(1'b1);
          end else begin
            bfly_r <= bfly_r + BW'(1'b1);
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state_r     <= IDLE;
          end
        end
        default: begin
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          state_r     <= IDLE;
        end
      endcase
    end
  end

  // in_ready is forced low for the whole cycle in which reset is asserted.
  assign in_ready  = in_ready_r & ~rst;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;

  for (genvar k = 0; k < D; k++) begin : g_out
`ifdef NTT_NATURAL_ORDER_EN
    assign an[k*N +: N] = buf_r[bitrev(k, LOGD)];
`else
    assign an[k*N +: N] = buf_r[k];
`endif
  end

endmodule
